sdram_wr_drain: RTL and testbench

- Read-side consumer of the write-path async FIFO in the SDRAM controller.
- Watches the FIFO fill level and requests a write burst from the SDRAM command engine once enough data is buffered.
- Pops FIFO words beat-by-beat as the engine pulls data, and advances a wrapping SDRAM write address after each completed burst.
- Runs entirely in the FIFO read clock domain.

---
 rtl/sdram_pkg.sv | 11 +
 rtl/sdram_addr_gen.sv | 42 ++++
 rtl/sdram_wr_drain.sv | 83 ++++++++
 tb/tb_sdram_wr_drain.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// sdram_pkg: write-drain FSM state encoding and the default burst/address geometry shared with the command engine
package sdram_pkg;
  localparam int BURST_LEN_DEF = 8;
  localparam int ADDR_WIDTH_DEF = 24;
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    DATA      = 2'd2,
    WAIT_DONE = 2'd3
  } wr_state_t;
endpackage

// File: rtl/sdram_addr_gen.sv
// sdram_addr_gen: wrapping burst address register and burst-length latch (sys_clk, sys_rst; cnt in, load latches len, advance steps addr by len)
module sdram_addr_gen
  import sdram_pkg::*;
#(
  parameter int          CNT_WIDTH  = 8,
  parameter int          BURST_LEN  = BURST_LEN_DEF,
  parameter int          ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned ADDR_BASE  = 0,
  parameter int unsigned ADDR_SPAN  = 1 << 20
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic [CNT_WIDTH-1:0]  cnt,
  input  logic                  load,
  input  logic                  advance,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [7:0]            len
);
  localparam logic [ADDR_WIDTH:0]   END  = (ADDR_WIDTH+1)'(ADDR_BASE + ADDR_SPAN);
  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(ADDR_BASE);
  localparam logic [31:0]           BL   = 32'(BURST_LEN);
  logic [ADDR_WIDTH:0] remain, sum;
  logic [31:0] cnt_w, rem_w, cap, len_nxt;
  always_comb begin
    remain  = END - {1'b0, addr};
    sum     = {1'b0, addr} + (ADDR_WIDTH+1)'(len);
    cnt_w   = 32'(cnt);
    // saturate the distance to region end so a wide address never truncates into a small value
    rem_w   = remain > (ADDR_WIDTH+1)'(BL) ? BL : 32'(remain);
    cap     = cnt_w < BL ? cnt_w : BL;
    len_nxt = cap < rem_w ? cap : rem_w;
  end
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      addr <= BASE;
      len  <= '0;
    end else begin
      if (load) len <= 8'(len_nxt);
      if (advance) addr <= sum == END ? BASE : sum[ADDR_WIDTH-1:0];
    end
  end
endmodule

// File: rtl/sdram_wr_drain.sv
// sdram_wr_drain: drains the write FIFO into SDRAM write bursts
//   fifo_*   : FIFO read side (empty, fill count, show-ahead data, pop)
//   flush_i  : drain a partial burst
//   wr_*     : request/ack, address/len, beat pull/data, done handshake with the command engine
//   busy_o, underrun_err_o : status
module sdram_wr_drain
  import sdram_pkg::*;
#(
  parameter int          DATA_WIDTH = 16,
  parameter int          CNT_WIDTH  = 8,
  parameter int          BURST_LEN  = BURST_LEN_DEF,
  parameter int          ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned ADDR_BASE  = 0,
  parameter int unsigned ADDR_SPAN  = 1 << 20
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  fifo_empty_i,
  input  logic [CNT_WIDTH-1:0]  fifo_data_num_i,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data_i,
  output logic                  fifo_rd_en_o,
  input  logic                  flush_i,
  output logic                  wr_req_o,
  input  logic                  wr_ack_i,
  output logic [ADDR_WIDTH-1:0] wr_addr_o,
  output logic [7:0]            wr_len_o,
  input  logic                  wr_data_en_i,
  output logic [DATA_WIDTH-1:0] wr_data_o,
  input  logic                  wr_done_i,
  output logic                  busy_o,
  output logic                  underrun_err_o
);
  localparam logic [CNT_WIDTH:0] BL_CNT = (CNT_WIDTH+1)'(BURST_LEN);
  wr_state_t state, state_nxt;
  logic [7:0] beat_cnt;
  logic flush_pend, start, pulling, last_beat;
  assign pulling   = state == DATA && wr_data_en_i;
  assign start     = state == IDLE && ({1'b0, fifo_data_num_i} >= BL_CNT || (flush_pend && fifo_data_num_i != '0));
  assign last_beat = pulling && beat_cnt == wr_len_o - 8'd1;
  sdram_addr_gen #(
    .CNT_WIDTH (CNT_WIDTH),
    .BURST_LEN (BURST_LEN),
    .ADDR_WIDTH(ADDR_WIDTH),
    .ADDR_BASE (ADDR_BASE),
    .ADDR_SPAN (ADDR_SPAN)
  ) u_addr_gen (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .cnt    (fifo_data_num_i),
    .load   (start),
    .advance(state == WAIT_DONE && wr_done_i),
    .addr   (wr_addr_o),
    .len    (wr_len_o)
  );
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      state_nxt = start ? REQ : IDLE;
      REQ:       state_nxt = wr_ack_i ? DATA : REQ;
      DATA:      state_nxt = last_beat ? WAIT_DONE : DATA;
      WAIT_DONE: state_nxt = wr_done_i ? IDLE : WAIT_DONE;
      default:   state_nxt = IDLE;
    endcase
    fifo_rd_en_o = pulling & ~fifo_empty_i;
    wr_data_o    = fifo_rd_en_o ? fifo_rd_data_i : '0;
    wr_req_o     = state == REQ;
    busy_o       = state != IDLE;
  end
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state          <= IDLE;
      beat_cnt       <= '0;
      flush_pend     <= 1'b0;
      underrun_err_o <= 1'b0;
    end else begin
      state          <= state_nxt;
      // a new flush in the clearing cycle keeps the pending flag
      flush_pend     <= flush_i | (flush_pend & ~(state == IDLE && fifo_data_num_i == '0));
      underrun_err_o <= underrun_err_o | (pulling & fifo_empty_i);
      beat_cnt       <= (state == REQ && wr_ack_i) ? '0 : pulling ? beat_cnt + 8'd1 : beat_cnt;
    end
  end
endmodule

// File: tb/tb_sdram_wr_drain.sv
// tb_sdram_wr_drain: directed bench with a small FIFO model and an engine driven from tasks
module tb_sdram_wr_drain;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0, wr_ack = 1'b0, wr_data_en = 1'b0, wr_done = 1'b0, starve = 1'b0;
  logic fifo_empty, fifo_rd_en, wr_req, busy, underrun;
  logic [7:0] fifo_cnt, wr_len;
  logic [15:0] fifo_data, wr_data;
  logic [23:0] wr_addr;
  logic [15:0] mem [0:255];
  logic [7:0] wp = 8'd0, rp = 8'd0;
  int chk = 0, pass = 0;

  always #5 clk = ~clk;

  assign fifo_empty = starve | (wp == rp);
  assign fifo_cnt   = starve ? 8'd0 : wp - rp;
  assign fifo_data  = mem[rp];

  always @(posedge clk) if (fifo_rd_en) rp <= rp + 8'd1;

  sdram_wr_drain #(.ADDR_SPAN(16)) dut (
    .sys_clk(clk), .sys_rst(rst),
    .fifo_empty_i(fifo_empty), .fifo_data_num_i(fifo_cnt), .fifo_rd_data_i(fifo_data), .fifo_rd_en_o(fifo_rd_en),
    .flush_i(flush), .wr_req_o(wr_req), .wr_ack_i(wr_ack), .wr_addr_o(wr_addr), .wr_len_o(wr_len),
    .wr_data_en_i(wr_data_en), .wr_data_o(wr_data), .wr_done_i(wr_done),
    .busy_o(busy), .underrun_err_o(underrun)
  );

  task automatic push_n(input logic [15:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      mem[wp] = first + 16'(i);
      wp = wp + 8'd1;
    end
  endtask

  task automatic drain();
    @(negedge clk);
    wp = rp;
  endtask

  task automatic pulse_flush();
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
  endtask

  task automatic do_burst(input int exp_addr, input int exp_len, input logic [15:0] first, input bit gap, input int starve_at);
    bit seen = 1'b0;
    int nxt = (exp_addr + exp_len) % 16;
    for (int k = 0; k < 12 && !seen; k++) begin
      @(negedge clk); #1;
      seen = wr_req;
    end
    chk++; if (!seen) $display("FAIL req_seen: wr_req_o never rose (want 1)"); else pass++;
    chk++; if (wr_addr !== 24'(exp_addr)) $display("FAIL req_addr: got %0d want %0d", wr_addr, exp_addr); else pass++;
    chk++; if (wr_len !== 8'(exp_len)) $display("FAIL req_len: got %0d want %0d", wr_len, exp_len); else pass++;
    @(negedge clk); wr_ack = 1'b1; #1;
    chk++; if (wr_req !== 1'b1) $display("FAIL req_held: got %b want 1", wr_req); else pass++;
    @(negedge clk); wr_ack = 1'b0; #1;
    chk++; if (wr_req !== 1'b0 || busy !== 1'b1) $display("FAIL req_drop: req %b busy %b want 0 1", wr_req, busy); else pass++;
    for (int i = 0; i < exp_len; i++) begin
      if (gap && i > 0) begin
        for (int g = 0; g < 2; g++) begin
          @(negedge clk); wr_data_en = 1'b0; #1;
          chk++; if (wr_data !== 16'h0 || fifo_rd_en !== 1'b0) $display("FAIL gap_beat: data %h pop %b want 0000 0", wr_data, fifo_rd_en); else pass++;
        end
      end
      @(negedge clk);
      if (i == starve_at) starve = 1'b1;
      wr_data_en = 1'b1; #1;
      if (starve) begin
        chk++; if (wr_data !== 16'h0 || fifo_rd_en !== 1'b0) $display("FAIL underrun_beat%0d: data %h pop %b want 0000 0", i, wr_data, fifo_rd_en); else pass++;
      end else begin
        chk++; if (wr_data !== first + 16'(i) || fifo_rd_en !== 1'b1) $display("FAIL beat%0d: data %h pop %b want %h 1", i, wr_data, fifo_rd_en, first + 16'(i)); else pass++;
      end
    end
    @(negedge clk); wr_data_en = 1'b1; #1;
    chk++; if (busy !== 1'b1 || fifo_rd_en !== 1'b0 || wr_data !== 16'h0) $display("FAIL wait_done: busy %b pop %b data %h want 1 0 0000", busy, fifo_rd_en, wr_data); else pass++;
    @(negedge clk); wr_data_en = 1'b0; wr_done = 1'b1;
    @(negedge clk); wr_done = 1'b0; #1;
    chk++; if (busy !== 1'b0 || wr_addr !== 24'(nxt)) $display("FAIL done_addr: busy %b addr %0d want 0 %0d", busy, wr_addr, nxt); else pass++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    chk++; if ({wr_req, fifo_rd_en, busy, underrun} !== 4'b0 || wr_addr !== 24'd0 || wr_len !== 8'd0 || wr_data !== 16'h0)
      $display("FAIL reset: req %b pop %b busy %b err %b addr %0d len %0d data %h want all 0", wr_req, fifo_rd_en, busy, underrun, wr_addr, wr_len, wr_data);
    else pass++;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_full_burst();
    push_n(16'hA000, 8);
    do_burst(0, 8, 16'hA000, 1'b0, -1);
    chk++; if (rp !== wp) $display("FAIL full_pops: fifo left %0d words want 0", wp - rp); else pass++;
  endtask

  task automatic test_wrap();
    push_n(16'hB000, 8);
    do_burst(8, 8, 16'hB000, 1'b0, -1);
  endtask

  task automatic test_gapped();
    push_n(16'hC000, 8);
    do_burst(0, 8, 16'hC000, 1'b1, -1);
  endtask

  task automatic test_underrun();
    chk++; if (underrun !== 1'b0) $display("FAIL underrun_pre: got %b want 0", underrun); else pass++;
    push_n(16'hD000, 8);
    do_burst(8, 8, 16'hD000, 1'b0, 5);
    chk++; if (underrun !== 1'b1) $display("FAIL underrun_sticky: got %b want 1", underrun); else pass++;
    starve = 1'b0;
    drain();
  endtask

  task automatic test_flush();
    int bad = 0;
    push_n(16'hE000, 3);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); #1;
      if (wr_req) bad++;
    end
    chk++; if (bad != 0) $display("FAIL pre_flush_req: %0d request cycles want 0", bad); else pass++;
    pulse_flush();
    do_burst(0, 3, 16'hE000, 1'b0, -1);
    push_n(16'hE100, 2);
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); #1;
      if (wr_req) bad++;
    end
    chk++; if (bad != 0) $display("FAIL flush_cleared: %0d request cycles want 0", bad); else pass++;
    drain();
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    push_n(16'hF000, 8);
    for (int k = 0; k < 12 && !seen; k++) begin
      @(negedge clk); #1;
      seen = wr_req;
    end
    chk++; if (!seen || wr_addr !== 24'd3) $display("FAIL rstmid_req: req %b addr %0d want 1 3", seen, wr_addr); else pass++;
    @(negedge clk); wr_ack = 1'b1;
    @(negedge clk); wr_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); wr_data_en = 1'b1;
    end
    @(negedge clk); wr_data_en = 1'b1; #1;
    chk++; if (wr_data !== 16'hF003) $display("FAIL rstmid_beat4: data %h want f003", wr_data); else pass++;
    #1 rst = 1'b1; #1;
    chk++; if ({wr_req, fifo_rd_en, busy, underrun} !== 4'b0 || wr_addr !== 24'd0 || wr_len !== 8'd0 || wr_data !== 16'h0)
      $display("FAIL rstmid_outputs: req %b pop %b busy %b err %b addr %0d len %0d data %h want all 0", wr_req, fifo_rd_en, busy, underrun, wr_addr, wr_len, wr_data);
    else pass++;
    @(negedge clk); rst = 1'b0; wr_data_en = 1'b0;
    @(negedge clk); wr_done = 1'b1;
    @(negedge clk); wr_done = 1'b0; #1;
    chk++; if (busy !== 1'b0 || wr_addr !== 24'd0 || wr_req !== 1'b0) $display("FAIL stray_done: busy %b addr %0d req %b want 0 0 0", busy, wr_addr, wr_req); else pass++;
    chk++; if (8'(wp - rp) !== 8'd5) $display("FAIL rstmid_fifo: %0d words left want 5", wp - rp); else pass++;
    drain();
  endtask

  task automatic test_len_trunc();
    push_n(16'h1000, 8);
    do_burst(0, 8, 16'h1000, 1'b0, -1);
    push_n(16'h2000, 4);
    pulse_flush();
    do_burst(8, 4, 16'h2000, 1'b0, -1);
    push_n(16'h3000, 8);
    do_burst(12, 4, 16'h3000, 1'b0, -1);
    chk++; if (8'(wp - rp) !== 8'd4) $display("FAIL trunc_left: %0d words left want 4", wp - rp); else pass++;
    drain();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    test_full_burst();
    test_wrap();
    test_gapped();
    test_underrun();
    test_flush();
    test_reset_mid();
    test_len_trunc();
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end
endmodule
